burst_data_memory: RTL and testbench

Second-generation data memory for the pipelined MIPS core: a byte-addressable, big-endian RAM mapped at a fixed base address. It supports single-word, half-word and byte accesses, plus 4/8/16-beat bursts with internal address auto-increment. It sits behind the MEM stage and the future cache refill path, and adds range/alignment error reporting and a registered read-valid strobe.

---
 rtl/burst_data_memory_pkg.sv | 36 +++
 rtl/burst_data_memory_if.sv | 26 ++
 rtl/burst_data_memory_range_check.sv | 44 ++++
 rtl/burst_data_memory.sv | 148 ++++++++++++++
 tb/tb_burst_data_memory.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/burst_data_memory_pkg.sv
// Shared definitions for the burst data memory and its range checker:
// request encodings, FSM states and the default base address.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_1  = 2'b00,
        SZ_4  = 2'b01,
        SZ_8  = 2'b10,
        SZ_16 = 2'b11
    } access_size_e;

    typedef enum logic [1:0] {
        W_FULL = 2'b00,
        W_HALF = 2'b01,
        W_BYTE = 2'b10,
        W_RSVD = 2'b11
    } width_sel_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WBURST = 2'b01,
        RBURST = 2'b10
    } state_e;

    localparam logic [31:0] START_ADDR_DEF = 32'h8002_0000;

    function automatic logic [4:0] beats_of(input logic [1:0] size);
        case (size)
            SZ_1:    return 5'd1;
            SZ_4:    return 5'd4;
            SZ_8:    return 5'd8;
            default: return 5'd16;
        endcase
    endfunction

endpackage

// File: rtl/burst_data_memory_if.sv
// Request/response bus between the MEM stage (master) and the data memory (slave).
interface burst_data_memory_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data_in;
    logic [1:0]            access_size;
    logic [1:0]            width_sel;
    logic                  rw;
    logic                  enable;
    logic                  busy;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  error;

    modport master (
        output address, data_in, access_size, width_sel, rw, enable,
        input  busy, data_out, data_valid, error
    );

    modport slave (
        input  address, data_in, access_size, width_sel, rw, enable,
        output busy, data_out, data_valid, error
    );
endinterface

// File: rtl/burst_data_memory_range_check.sv
// Combinational request legality check (alignment, range, width/size combination),
// shared with the instruction memory.
module mem_range_check
    import mem_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH_BYTES = 1048576,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR  = START_ADDR_DEF,
    parameter int                    IDX_W       = $clog2(DEPTH_BYTES)
) (
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [1:0]            access_size,
    input  logic [1:0]            width_sel,
    output logic                  req_ok,
    output logic [IDX_W-1:0]      idx
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int EW    = ADDR_WIDTH + 8;

    logic [ADDR_WIDTH-1:0] off;
    logic [EW-1:0]         end_byte;
    logic                  aligned;
    logic                  width_ok;

    // Addresses below the base wrap to huge offsets and fail the range test.
    assign off      = address - START_ADDR;
    assign end_byte = EW'(off) + EW'(beats_of(access_size)) * EW'(BYTES);
    assign idx      = off[IDX_W-1:0];

    always_comb begin
        aligned = 1'b1;
        case (width_sel)
            W_FULL:  aligned = ((address % ADDR_WIDTH'(BYTES)) == '0);
            W_HALF:  aligned = !address[0];
            default: aligned = 1'b1;
        endcase
    end

    assign width_ok = (width_sel != W_RSVD) &&
                      ((width_sel == W_FULL) || (access_size == SZ_1));
    assign req_ok   = aligned && width_ok && (end_byte <= EW'(DEPTH_BYTES));

endmodule

// File: rtl/burst_data_memory.sv
// Big-endian byte-addressable data memory with 1/4/8/16-beat bursts,
// sub-word access, registered read data and request error reporting.
module burst_data_memory
    import mem_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH_BYTES = 1048576,
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR  = START_ADDR_DEF
) (
    input  logic                clock,
    input  logic                reset_n,
    burst_data_memory_if.slave  bus
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int IDX_W = $clog2(DEPTH_BYTES);

    logic [7:0] mem [0:DEPTH_BYTES-1];

    state_e                state;
    logic [4:0]            cnt;
    logic [4:0]            last;
    logic [IDX_W-1:0]      ptr;

    logic                  req_ok;
    logic [IDX_W-1:0]      req_idx;

    logic                  perform_p0;
    logic                  wr_p0;
    width_sel_e            width_p0;
    logic [IDX_W-1:0]      ptr_p0;
    logic [DATA_WIDTH-1:0] rd_word_p0;

    mem_range_check #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DEPTH_BYTES (DEPTH_BYTES),
        .START_ADDR  (START_ADDR),
        .IDX_W       (IDX_W)
    ) u_range_check (
        .address     (bus.address),
        .access_size (bus.access_size),
        .width_sel   (bus.width_sel),
        .req_ok      (req_ok),
        .idx         (req_idx)
    );

    // Stage p0: decide which beat (if any) is performed at the coming edge.
    always_comb begin
        perform_p0 = 1'b0;
        wr_p0      = 1'b0;
        width_p0   = W_FULL;
        ptr_p0     = ptr;
        case (state)
            IDLE: begin
                perform_p0 = bus.enable && req_ok;
                wr_p0      = !bus.rw;
                width_p0   = width_sel_e'(bus.width_sel);
                ptr_p0     = req_idx;
            end
            WBURST: begin
                perform_p0 = bus.enable;
                wr_p0      = 1'b1;
            end
            RBURST: begin
                perform_p0 = bus.enable;
                wr_p0      = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_word_p0 = '0;
        case (width_p0)
            W_HALF:  rd_word_p0[15:0] = {mem[ptr_p0], mem[ptr_p0 + 1'b1]};
            W_BYTE:  rd_word_p0[7:0]  = mem[ptr_p0];
            default: begin
                for (int b = 0; b < BYTES; b++)
                    rd_word_p0[DATA_WIDTH-1-8*b -: 8] = mem[ptr_p0 + IDX_W'(b)];
            end
        endcase
    end

    // Storage is never reset; a beat coinciding with reset is dropped.
    always_ff @(posedge clock) begin
        if (reset_n && perform_p0 && wr_p0) begin
            case (width_p0)
                W_HALF: begin
                    mem[ptr_p0]        <= bus.data_in[15:8];
                    mem[ptr_p0 + 1'b1] <= bus.data_in[7:0];
                end
                W_BYTE: mem[ptr_p0] <= bus.data_in[7:0];
                default: begin
                    for (int b = 0; b < BYTES; b++)
                        mem[ptr_p0 + IDX_W'(b)] <= bus.data_in[DATA_WIDTH-1-8*b -: 8];
                end
            endcase
        end
    end

    // Stage p1: registered FSM, burst bookkeeping and outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state          <= IDLE;
            cnt            <= '0;
            last           <= '0;
            ptr            <= '0;
            bus.busy       <= 1'b0;
            bus.data_out   <= '0;
            bus.data_valid <= 1'b0;
            bus.error      <= 1'b0;
        end else begin
            bus.error      <= 1'b0;
            bus.data_valid <= perform_p0 && !wr_p0;
            if (perform_p0 && !wr_p0)
                bus.data_out <= rd_word_p0;
            case (state)
                IDLE: begin
                    if (bus.enable) begin
                        if (!req_ok) begin
                            bus.error <= 1'b1;
                        end else if (bus.access_size != SZ_1) begin
                            state    <= bus.rw ? RBURST : WBURST;
                            cnt      <= 5'd1;
                            last     <= beats_of(bus.access_size) - 5'd1;
                            ptr      <= req_idx + IDX_W'(BYTES);
                            bus.busy <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (bus.enable) begin
                        if (cnt == last) begin
                            state    <= IDLE;
                            cnt      <= '0;
                            bus.busy <= 1'b0;
                        end else begin
                            cnt <= cnt + 5'd1;
                            ptr <= ptr + IDX_W'(BYTES);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_burst_data_memory.sv
// Directed bench for burst_data_memory: single/sub-word accesses, bursts with
// stalls, error rejection and reset mid-burst.
module tb_burst_data_memory;
    import mem_pkg::*;

    logic clock;
    logic reset_n;
    int   n_cmp;
    int   n_bad;

    burst_data_memory_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    burst_data_memory #(
        .DATA_WIDTH  (32),
        .DEPTH_BYTES (1048576),
        .ADDR_WIDTH  (32),
        .START_ADDR  (32'h8002_0000)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic en, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz, input logic [1:0] ws, input logic r);
        bus.enable      = en;
        bus.address     = a;
        bus.data_in     = d;
        bus.access_size = sz;
        bus.width_sel   = ws;
        bus.rw          = r;
    endtask

    // One-cycle request; leaves enable low afterwards.
    task automatic single(input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] ws, input logic r);
        drive(1'b1, a, d, SZ_1, ws, r);
        tick();
        bus.enable = 1'b0;
    endtask

    task automatic read_word(input string tag, input logic [31:0] a, input logic [31:0] exp);
        single(a, 32'h0, W_FULL, 1'b1);
        check({tag, "_dv"}, {31'b0, bus.data_valid}, 32'd1);
        check(tag, bus.data_out, exp);
    endtask

    task automatic write_burst(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] base);
        int n;
        n = int'(beats_of(sz));
        for (int i = 0; i < n; i++) begin
            drive(1'b1, a, base + 32'(i), sz, W_FULL, 1'b0);
            tick();
        end
        bus.enable = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        int beat_cnt;
        logic [31:0] got [0:7];
        logic [7:0] en_pat;
        n_cmp = 0;
        n_bad = 0;

        reset_n = 1'b0;
        drive(1'b0, 32'h0, 32'h0, SZ_1, W_FULL, 1'b0);
        tick();
        tick();
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_data_out", bus.data_out, 32'd0);
        check("rst_dv", {31'b0, bus.data_valid}, 32'd0);
        check("rst_err", {31'b0, bus.error}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Single word write and read-back
        single(32'h8002_0000, 32'hDEAD_BEEF, W_FULL, 1'b0);
        check("sw_busy", {31'b0, bus.busy}, 32'd0);
        check("sw_dv", {31'b0, bus.data_valid}, 32'd0);
        check("mem0", {24'b0, dut.mem[0]}, 32'h0000_00DE);
        check("mem3", {24'b0, dut.mem[3]}, 32'h0000_00EF);
        read_word("sw_rd", 32'h8002_0000, 32'hDEAD_BEEF);
        tick();
        check("sw_dv_drop", {31'b0, bus.data_valid}, 32'd0);
        check("sw_hold", bus.data_out, 32'hDEAD_BEEF);

        // 4-beat write then 4-beat read
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h8002_0010, 32'(i + 1), SZ_4, W_FULL, 1'b0);
            tick();
            check($sformatf("wr4_busy%0d", i), {31'b0, bus.busy}, (i < 3) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h8002_0010, 32'h0, SZ_4, W_FULL, 1'b1);
            tick();
            check($sformatf("rd4_dv%0d", i), {31'b0, bus.data_valid}, 32'd1);
            check($sformatf("rd4_data%0d", i), bus.data_out, 32'(i + 1));
        end
        bus.enable = 1'b0;
        tick();
        check("rd4_dv_end", {31'b0, bus.data_valid}, 32'd0);

        // 8-beat read with a 2-cycle stall after the third beat
        write_burst(32'h8002_0100, SZ_8, 32'h0000_0100);
        en_pat   = 8'b0;
        busy_cnt = 0;
        beat_cnt = 0;
        for (int t = 0; t < 10; t++) begin
            drive((t == 3 || t == 4) ? 1'b0 : 1'b1, 32'h8002_0100, 32'h0, SZ_8, W_FULL, 1'b1);
            tick();
            if (bus.busy) busy_cnt++;
            if (bus.data_valid) begin
                if (beat_cnt < 8) got[beat_cnt] = bus.data_out;
                beat_cnt++;
            end
        end
        bus.enable = 1'b0;
        check("rd8_beats", 32'(beat_cnt), 32'd8);
        check("rd8_busy_cycles", 32'(busy_cnt), 32'd9);
        for (int i = 0; i < 8; i++)
            check($sformatf("rd8_data%0d", i), got[i], 32'h100 + 32'(i));
        tick();
        check("rd8_idle_busy", {31'b0, bus.busy}, 32'd0);

        // Byte and half-word writes over a word
        single(32'h8002_0020, 32'h1122_3344, W_FULL, 1'b0);
        single(32'h8002_0021, 32'h5A5A_5AAB, W_BYTE, 1'b0);
        read_word("byte_merge", 32'h8002_0020, 32'h11AB_3344);
        single(32'h8002_0021, 32'h0, W_BYTE, 1'b1);
        check("byte_rd", bus.data_out, 32'h0000_00AB);
        single(32'h8002_0022, 32'h7777_BEEF, W_HALF, 1'b0);
        read_word("half_merge", 32'h8002_0020, 32'h11AB_BEEF);
        single(32'h8002_0020, 32'h0, W_HALF, 1'b1);
        check("half_rd", bus.data_out, 32'h0000_11AB);

        // Rejected requests
        single(32'h8002_0002, 32'hFFFF_FFFF, W_FULL, 1'b0);
        check("err_misalign", {31'b0, bus.error}, 32'd1);
        tick();
        check("err_pulse_end", {31'b0, bus.error}, 32'd0);
        read_word("err_misalign_mem", 32'h8002_0000, 32'hDEAD_BEEF);
        drive(1'b1, 32'h8011_FFE0, 32'hFFFF_FFFF, SZ_16, W_FULL, 1'b0);
        tick();
        bus.enable = 1'b0;
        check("err_range", {31'b0, bus.error}, 32'd1);
        check("err_range_busy", {31'b0, bus.busy}, 32'd0);
        single(32'h8001_0000, 32'hFFFF_FFFF, W_FULL, 1'b0);
        check("err_below", {31'b0, bus.error}, 32'd1);
        single(32'h8002_0020, 32'hFFFF_FFFF, W_RSVD, 1'b0);
        check("err_rsvd", {31'b0, bus.error}, 32'd1);
        drive(1'b1, 32'h8002_0020, 32'hFFFF_FFFF, SZ_4, W_HALF, 1'b0);
        tick();
        bus.enable = 1'b0;
        check("err_half_burst", {31'b0, bus.error}, 32'd1);
        read_word("err_mem_unchanged", 32'h8002_0020, 32'h11AB_BEEF);
        check("err_clear", {31'b0, bus.error}, 32'd0);

        // 8-beat burst ending exactly at the top of memory is legal
        drive(1'b1, 32'h8011_FFE0, 32'h0000_0E00, SZ_8, W_FULL, 1'b0);
        tick();
        check("top_accept_busy", {31'b0, bus.busy}, 32'd1);
        check("top_accept_err", {31'b0, bus.error}, 32'd0);
        for (int i = 1; i < 8; i++) begin
            drive(1'b1, 32'h0, 32'h0000_0E00 + 32'(i), SZ_1, W_FULL, 1'b1);
            tick();
        end
        bus.enable = 1'b0;
        read_word("top_last", 32'h8011_FFFC, 32'h0000_0E07);

        // Reset during a 16-beat write
        write_burst(32'h8002_0200, SZ_16, 32'hA000_0000);
        drive(1'b1, 32'h8002_0200, 32'hC000_0000, SZ_16, W_FULL, 1'b0);
        tick();
        drive(1'b1, 32'h0, 32'hC000_0001, SZ_1, W_FULL, 1'b1);
        tick();
        drive(1'b1, 32'h0, 32'hC000_0002, SZ_1, W_FULL, 1'b1);
        reset_n = 1'b0;
        tick();
        bus.enable = 1'b0;
        check("rstb_busy", {31'b0, bus.busy}, 32'd0);
        check("rstb_dv", {31'b0, bus.data_valid}, 32'd0);
        reset_n = 1'b1;
        read_word("rstb_beat0", 32'h8002_0200, 32'hC000_0000);
        read_word("rstb_beat1", 32'h8002_0204, 32'hC000_0001);
        read_word("rstb_beat2", 32'h8002_0208, 32'hA000_0002);
        read_word("rstb_beat3", 32'h8002_020C, 32'hA000_0003);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
